exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM-subset pipeline. It consumes the ID/EX pipeline register outputs and produces the ALU result, the branch target and the updated status register (NZCV) for the EX/MEM register and the ID stage.
- Contains the val2 generator, the 4-bit-command ALU, the CPSR flop, and an iterative 32-cycle shift-add multiplier.
- While the multiplier runs, the block stalls the upstream stages.

---
 rtl/exe_stage_pkg.sv | 46 ++++
 rtl/exe_stage_if.sv | 36 +++
 rtl/exe_stage_val2_gen.sv | 41 ++++
 rtl/exe_stage.sv | 144 ++++++++++++++
 tb/tb_exe_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Purpose: shared constants for the execute stage (ALU opcodes, shift types, flag indices, FSM states).
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package exe_stage_pkg;

  localparam int WORD_W = 32;

  // ALU opcodes as carried by ex_command
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_MUL = 4'b1111;

  // Immediate-shift types, shifter_operand[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // NZCV bit positions
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // Rotate right; amount 0 returns the word untouched (no RRX in this subset).
  function automatic logic [WORD_W-1:0] ror_word(input logic [WORD_W-1:0] x,
                                                 input logic [4:0]        amt);
    logic [5:0] back;
    back = 6'(WORD_W) - {1'b0, amt};
    ror_word = (amt == 5'd0) ? x : ((x >> amt) | (x << back));
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Purpose: ID/EX-to-EX bundle plus the EX results returned to EX/MEM and the ID stage.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the slave (execute stage) toward the upstream master.
// Ports: master = pipeline side driving operands; slave = execute stage producing results.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic [WORD_W-1:0] pc_in;
  logic [WORD_W-1:0] val_Rn;
  logic [WORD_W-1:0] val_Rm;
  logic [23:0]       signed_imm;
  logic [11:0]       shifter_operand;
  logic [3:0]        ex_command;
  logic [3:0]        status_in;
  logic              imm;
  logic              mem_access;
  logic              sr_update;
  logic [WORD_W-1:0] alu_result;
  logic [WORD_W-1:0] br_addr;
  logic [3:0]        status_reg;
  logic              stall;
  logic              result_valid;

  modport master (
    output pc_in, val_Rn, val_Rm, signed_imm, shifter_operand, ex_command,
           status_in, imm, mem_access, sr_update,
    input  alu_result, br_addr, status_reg, stall, result_valid
  );

  modport slave (
    input  pc_in, val_Rn, val_Rm, signed_imm, shifter_operand, ex_command,
           status_in, imm, mem_access, sr_update,
    output alu_result, br_addr, status_reg, stall, result_valid
  );

endinterface

// File: rtl/exe_stage_val2_gen.sv
// Purpose: second-operand generator (offset, rotated immediate, or immediate-shifted Rm).
// Latency: combinational.
// Backpressure: none.
// Ports: val_Rm/shifter_operand/imm/mem_access in, val2 out.
module exe_stage_val2_gen
  import exe_stage_pkg::*;
(
  input  logic [WORD_W-1:0] val_Rm,
  input  logic [11:0]       shifter_operand,
  input  logic              imm,
  input  logic              mem_access,
  output logic [WORD_W-1:0] val2
);

  logic [4:0] sh_amt;
  logic [1:0] sh_type;
  logic [4:0] rot_amt;

  assign sh_amt  = shifter_operand[11:7];
  assign sh_type = shifter_operand[6:5];
  assign rot_amt = {shifter_operand[11:8], 1'b0};

  // shifter_operand[4] (register-specified shift) is not supported and is
  // only consumed as part of the zero-extended memory offset.
  always_comb begin
    val2 = val_Rm;
    if (mem_access) begin
      val2 = {20'b0, shifter_operand};
    end else if (imm) begin
      val2 = ror_word({24'b0, shifter_operand[7:0]}, rot_amt);
    end else if (sh_amt != 5'd0) begin
      case (sh_type)
        SH_LSL:  val2 = val_Rm << sh_amt;
        SH_LSR:  val2 = val_Rm >> sh_amt;
        SH_ASR:  val2 = $signed(val_Rm) >>> sh_amt;
        default: val2 = ror_word(val_Rm, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Purpose: EX stage: val2, ALU, NZCV register, branch target and iterative shift-add MUL.
// Latency: 1 cycle for ALU ops; MUL occupies 34 cycles (result on the last).
// Backpressure: stall held high for 33 cycles of a MUL, freezing PC, IF/ID and ID/EX.
// Ports: clk, rst (async, active-high), bus (exe_stage_if.slave).
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int MUL_CYCLES = 32   // one iteration per multiplier bit
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam int MSB   = WORD_WIDTH - 1;

  mul_state_t            state, state_next;
  logic [WORD_WIDTH-1:0] val2;
  logic [WORD_WIDTH-1:0] result;
  logic [WORD_WIDTH:0]   sum;
  logic [3:0]            nzcv_next;
  logic [3:0]            status_q;
  logic                  c_new, v_new, flags_upd, stall;
  logic [WORD_WIDTH-1:0] prod, mcand, mplier;
  logic [CNT_W-1:0]      count;
  logic                  unused_status_bits;

  // Only the carry of the ID/EX snapshot feeds the ALU.
  assign unused_status_bits = ^{bus.status_in[FLAG_N], bus.status_in[FLAG_Z], bus.status_in[FLAG_V]};

  exe_stage_val2_gen u_val2 (
    .val_Rm          (bus.val_Rm),
    .shifter_operand (bus.shifter_operand),
    .imm             (bus.imm),
    .mem_access      (bus.mem_access),
    .val2            (val2)
  );

  assign bus.br_addr = bus.pc_in + {{6{bus.signed_imm[23]}}, bus.signed_imm, 2'b00};

  // ALU. Subtraction is done as Rn + ~val2 + cin so the carry out is ARM's NOT-borrow.
  always_comb begin
    sum       = '0;
    result    = '0;
    flags_upd = 1'b1;
    c_new     = status_q[FLAG_C];
    v_new     = status_q[FLAG_V];
    case (bus.ex_command)
      EXE_MOV: result = val2;
      EXE_MVN: result = ~val2;
      EXE_ADD, EXE_ADC: begin
        sum    = {1'b0, bus.val_Rn} + {1'b0, val2}
               + {{WORD_WIDTH{1'b0}}, (bus.ex_command == EXE_ADC) & bus.status_in[FLAG_C]};
        result = sum[MSB:0];
        c_new  = sum[WORD_WIDTH];
        v_new  = (bus.val_Rn[MSB] == val2[MSB]) && (result[MSB] != bus.val_Rn[MSB]);
      end
      EXE_SUB, EXE_SBC: begin
        sum    = {1'b0, bus.val_Rn} + {1'b0, ~val2}
               + {{WORD_WIDTH{1'b0}}, (bus.ex_command == EXE_SUB) | bus.status_in[FLAG_C]};
        result = sum[MSB:0];
        c_new  = sum[WORD_WIDTH];
        v_new  = (bus.val_Rn[MSB] != val2[MSB]) && (result[MSB] != bus.val_Rn[MSB]);
      end
      EXE_AND: result = bus.val_Rn & val2;
      EXE_ORR: result = bus.val_Rn | val2;
      EXE_EOR: result = bus.val_Rn ^ val2;
      EXE_MUL: result = prod;
      default: flags_upd = 1'b0;
    endcase
    nzcv_next = flags_upd ? {result[MSB], (result == '0), c_new, v_new} : status_q;
  end

  assign bus.alu_result = result;

  // Multiplier sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ex_command == EXE_MUL) begin
          state_next = ST_BUSY;
          stall      = 1'b1;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (count == CNT_W'(MUL_CYCLES - 1)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Reset must release the upstream freeze even while a MUL is still presented.
    if (rst) stall = 1'b0;
  end

  assign bus.stall        = stall;
  assign bus.result_valid = ~stall;

  // Operands are captured once in IDLE; upstream is frozen during BUSY so the
  // inputs are never re-sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ex_command == EXE_MUL) begin
            mcand  <= bus.val_Rn;
            mplier <= val2;
            prod   <= '0;
            count  <= '0;
          end
        end
        ST_BUSY: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           status_q <= 4'b0000;
    else if (bus.sr_update && !stall)  status_q <= nzcv_next;
  end

  assign bus.status_reg = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// Purpose: self-checking bench for exe_stage, directed vectors plus random ops against a model.
// Latency: inputs driven 1 time unit after posedge, outputs compared on negedge.
// Backpressure: MUL stall length is predicted by the model (33 cycles), not waited on.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [23:0] si;
    logic [11:0] so;
    logic [3:0]  cmd;
    logic [3:0]  sin;
    logic        imm;
    logic        mem;
    logic        sr;
  } op_t;

  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_res, exp_br;
  logic [3:0]  exp_status, exp_nxt;
  logic        exp_stall, exp_rv, res_chk;
  logic        chk_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                         input logic imm_b, input logic mem);
    logic [63:0] w;
    int amt;
    if (mem) return {20'b0, so};
    if (imm_b) begin
      amt = 2 * int'(so[11:8]);
      w = {24'b0, so[7:0], 24'b0, so[7:0]} >> amt;
      return w[31:0];
    end
    amt = int'(so[11:7]);
    case (so[6:5])
      2'd0:    w = {32'b0, rm} << amt;
      2'd1:    w = {32'b0, rm} >> amt;
      2'd2:    w = {{32{rm[31]}}, rm} >> amt;
      default: w = {rm, rm} >> amt;
    endcase
    return w[31:0];
  endfunction

  function automatic void m_alu(input logic [31:0] rn, input logic [31:0] v2, input logic [3:0] cmd,
                                input logic cin, input logic [3:0] cur,
                                output logic [31:0] res, output logic [3:0] nzcv);
    logic [63:0] u, ci;
    longint a, b, s;
    logic c, v, defined;
    a = longint'($signed(rn));
    b = longint'($signed(v2));
    c = cur[1];
    v = cur[0];
    defined = 1'b1;
    res = 32'd0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010, 4'b0011: begin
        ci  = (cmd == 4'b0011) ? {63'b0, cin} : 64'd0;
        u   = {32'b0, rn} + {32'b0, v2} + ci;
        res = u[31:0];
        c   = u[32];
        s   = a + b + longint'(ci);
        v   = (s > IMAX) || (s < IMIN);
      end
      4'b0100, 4'b0101: begin
        ci  = (cmd == 4'b0101) ? {63'b0, ~cin} : 64'd0;   // borrow
        u   = {32'b0, rn} - {32'b0, v2} - ci;
        res = u[31:0];
        c   = ({32'b0, rn} >= ({32'b0, v2} + ci));
        s   = a - b - longint'(ci);
        v   = (s > IMAX) || (s < IMIN);
      end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      4'b1111: begin
        u   = {32'b0, rn} * {32'b0, v2};
        res = u[31:0];
      end
      default: defined = 1'b0;
    endcase
    nzcv = defined ? {res[31], (res == 32'd0), c, v} : cur;
  endfunction

  function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [23:0] si);
    longint off, t;
    off = longint'({40'b0, si});
    if (off >= 8388608) off = off - 16777216;
    t = longint'({32'b0, pc}) + off * 4;
    return t[31:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(bus.stall), 32'(exp_stall));
      check("result_valid", 32'(bus.result_valid), 32'(exp_rv));
      check("status_reg", 32'(bus.status_reg), 32'(exp_status));
      check("br_addr", bus.br_addr, exp_br);
      if (res_chk && exp_rv) check("alu_result", bus.alu_result, exp_res);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input op_t o);
    bus.pc_in = o.pc;            bus.val_Rn = o.rn;          bus.val_Rm = o.rm;
    bus.signed_imm = o.si;       bus.shifter_operand = o.so; bus.ex_command = o.cmd;
    bus.status_in = o.sin;       bus.imm = o.imm;            bus.mem_access = o.mem;
    bus.sr_update = o.sr;
    m_alu(o.rn, m_val2(o.rm, o.so, o.imm, o.mem), o.cmd, o.sin[1], exp_status, exp_res, exp_nxt);
    exp_br    = m_br(o.pc, o.si);
    exp_stall = 1'b0;
    exp_rv    = 1'b1;
    res_chk   = 1'b1;
  endtask

  function automatic op_t mk(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                             input logic [11:0] so, input logic imm_b, input logic sr,
                             input logic [3:0] sin);
    op_t o;
    o = '0;
    o.pc = 32'h0000_1000; o.cmd = cmd; o.rn = rn; o.rm = rm; o.so = so;
    o.imm = imm_b; o.sr = sr; o.sin = sin;
    return o;
  endfunction

  task automatic run_op(input op_t o, input bit lit_en, input logic [31:0] lit_res,
                        input bit st_en, input logic [3:0] lit_st);
    apply(o);
    if (o.cmd == 4'b1111) begin
      // 1 IDLE + 32 BUSY cycles frozen, result on the following cycle
      exp_stall = 1'b1;
      exp_rv    = 1'b0;
      repeat (33) step();
      exp_stall = 1'b0;
      exp_rv    = 1'b1;
    end
    if (lit_en) begin
      @(negedge clk);
      check("literal_result", bus.alu_result, lit_res);
    end
    step();
    if (o.sr) exp_status = exp_nxt;
    if (st_en) begin
      apply('0);
      @(negedge clk);
      check("literal_status", 32'(bus.status_reg), 32'(lit_st));
      step();
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    logic [3:0] cmds [13];
    cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
             4'b0111, 4'b1000, 4'b0000, 4'b1010, 4'b1111, 4'b1100};

    // Reset state
    exp_status = 4'b0000;
    apply('0);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_status", 32'(bus.status_reg), 32'h0);
    check("reset_stall", 32'(bus.stall), 32'h0);
    step();
    rst = 1'b0;
    step();

    // ADD 0xFFFFFFFF + 1 -> 0, Z and C set
    run_op(mk(EXE_ADD, 32'hFFFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1, 4'h0), 1, 32'h0, 1, 4'b0110);
    // Rotated immediate 0xFF ror 8
    run_op(mk(EXE_MOV, 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 4'h0), 1, 32'hFF00_0000, 0, 4'h0);
    // LSR #1 and ASR #1 of 0x80000000
    run_op(mk(EXE_MOV, 32'h0, 32'h8000_0000, 12'h0A0, 1'b0, 1'b0, 4'h0), 1, 32'h4000_0000, 0, 4'h0);
    run_op(mk(EXE_MOV, 32'h0, 32'h8000_0000, 12'h0C0, 1'b0, 1'b0, 4'h0), 1, 32'hC000_0000, 0, 4'h0);
    // SBC 5 - 3 with C=0 -> 1
    run_op(mk(EXE_SBC, 32'd5, 32'h0, 12'h003, 1'b1, 1'b0, 4'h0), 1, 32'h1, 0, 4'h0);
    // CMP 3,5 -> N=1, Z=0, C=0, V=0
    run_op(mk(EXE_SUB, 32'd3, 32'h0, 12'h005, 1'b1, 1'b1, 4'h0), 1, 32'hFFFF_FFFE, 1, 4'b1000);

    // Branch target with negative offset
    o = mk(EXE_MOV, 32'h0, 32'h0, 12'h000, 1'b0, 1'b0, 4'h0);
    o.pc = 32'h0000_0100;
    o.si = 24'hFFFFFE;
    apply(o);
    @(negedge clk);
    check("literal_br_addr", bus.br_addr, 32'h0000_00F8);
    step();

    // MUL -1 * 7 after setting Z,C: N=1, C kept, V kept
    run_op(mk(EXE_ADD, 32'hFFFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1, 4'h0), 0, 32'h0, 1, 4'b0110);
    run_op(mk(EXE_MUL, 32'hFFFF_FFFF, 32'd7, 12'h000, 1'b0, 1'b1, 4'h0), 1, 32'hFFFF_FFF9, 1, 4'b1010);

    // Reset during BUSY (iteration 10)
    apply(mk(EXE_MUL, 32'h0001_2345, 32'd3, 12'h000, 1'b0, 1'b1, 4'h0));
    exp_stall = 1'b1;
    exp_rv    = 1'b0;
    repeat (11) step();
    rst        = 1'b1;
    exp_status = 4'b0000;
    exp_stall  = 1'b0;
    exp_rv     = 1'b1;
    res_chk    = 1'b0;
    #1;
    check("rst_mid_mul_stall", 32'(bus.stall), 32'h0);
    check("rst_mid_mul_status", 32'(bus.status_reg), 32'h0);
    step();
    apply('0);
    step();
    rst = 1'b0;
    run_op(mk(EXE_ADD, 32'hFFFF_FFFF, 32'h0, 12'h002, 1'b1, 1'b1, 4'h0), 1, 32'h1, 1, 4'b0010);

    // Random operations against the model
    for (int i = 0; i < 250; i++) begin
      o.pc  = $urandom();
      o.rn  = rnd_word();
      o.rm  = rnd_word();
      o.si  = 24'($urandom());
      o.so  = 12'($urandom_range(0, 4095));
      o.cmd = cmds[$urandom_range(0, 12)];
      o.sin = 4'($urandom_range(0, 15));
      o.imm = 1'($urandom_range(0, 1));
      o.mem = ($urandom_range(0, 7) == 0);
      o.sr  = 1'($urandom_range(0, 1));
      run_op(o, 0, 32'h0, 0, 4'h0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
